myproject_mul_share_arb: RTL

- Round-robin arbiter and two-stage pipeline sequencer that time-shares one 16s×10s→25 combinational signed multiplier (NUM_STAGE=0) among NUM_REQ requesters.
- Sits between the layer-compute units and the single multiplier instance.
- Registers the operands into the multiplier and the product out of it.
- Returns each result tagged with its requester ID over a valid/ready channel with full backpressure.

---
 rtl/myproject_mul_share_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/myproject_mul_share_arb.sv
// Purpose : round-robin arbiter + 2-stage sequencer sharing one signed multiplier among NUM_REQ requesters.
// Latency : accept at edge T -> operands registered at T, product registered at T+1 (res_valid visible cycle T+1).
// Backpr. : full valid/ready; stage 2 holds while res_ready low, stage 1 refills whenever empty.
//
// Ports:
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   req_valid/din0/din1   per-requester operands, packed requester i at [i*W +: W]
//   req_ready             one-hot (or zero) grant, qualified by pipeline advance
//   mul_din0/1, mul_dout  registered operands to / combinational product from the shared multiplier
//   res_valid/id/data     tagged result, res_ready downstream accept
//   busy                  any transaction in flight
module myproject_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 25
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DIN0_WIDTH-1:0]          mul_din0,
    output logic [DIN1_WIDTH-1:0]          mul_din1,
    input  logic [DOUT_WIDTH-1:0]          mul_dout,
    output logic                           res_valid,
    output logic [ID_WIDTH-1:0]            res_id,
    output logic [DOUT_WIDTH-1:0]          res_data,
    input  logic                           res_ready,
    output logic                           busy
);

    localparam logic [ID_WIDTH:0]   LP_NREQ = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LP_LAST = ID_WIDTH'(NUM_REQ - 1);

    // Pipeline state
    logic                  r_s1_valid;
    logic [ID_WIDTH-1:0]   r_s1_id;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [DIN0_WIDTH-1:0] r_mul_din0;
    logic [DIN1_WIDTH-1:0] r_mul_din1;
    logic                  r_res_valid;
    logic [ID_WIDTH-1:0]   r_res_id;
    logic [DOUT_WIDTH-1:0] r_res_data;

    // Combinational arbitration / advance
    logic                  w_adv1;
    logic                  w_adv2;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_grant;
    logic [ID_WIDTH:0]     w_idx;
    logic                  w_accept;
    logic [ID_WIDTH-1:0]   w_rr_next;
    logic [DIN0_WIDTH-1:0] w_sel_din0;
    logic [DIN1_WIDTH-1:0] w_sel_din1;
    logic [NUM_REQ-1:0]    w_req_ready;

    assign w_adv2 = !r_res_valid || res_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // Rotating priority scan: offsets 0..NUM_REQ-1 from rr_ptr, wrapped
    // by a single conditional subtract so non-power-of-two NUM_REQ works.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (w_idx >= LP_NREQ) begin
                w_idx = w_idx - LP_NREQ;
            end
            if (!w_found && req_valid[w_idx[ID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[ID_WIDTH-1:0];
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_sel_din0 = '0;
        w_sel_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == w_grant) begin
                w_sel_din0 = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                w_sel_din1 = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Ready is held low during reset so nothing handshakes into a block
    // that is about to discard it.
    always_comb begin
        w_req_ready = '0;
        if (w_found && !ap_rst) begin
            w_req_ready[w_grant] = w_adv1;
        end
    end

    assign w_accept  = w_found && w_adv1 && !ap_rst;
    assign w_rr_next = (w_grant == LP_LAST) ? '0 : w_grant + ID_WIDTH'(1);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_rr_ptr    <= '0;
            r_mul_din0  <= '0;
            r_mul_din1  <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
        end else begin
            // Stage 1: operand registers feeding the multiplier
            if (w_adv1) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_mul_din0 <= w_sel_din0;
                    r_mul_din1 <= w_sel_din1;
                    r_s1_id    <= w_grant;
                    r_rr_ptr   <= w_rr_next;
                end
            end
            // Stage 2: capture product; id/data only move with a real item
            if (w_adv2) begin
                r_res_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res_data <= mul_dout;
                    r_res_id   <= r_s1_id;
                end
            end
        end
    end

    assign req_ready = w_req_ready;
    assign mul_din0  = r_mul_din0;
    assign mul_din1  = r_mul_din1;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_data  = r_res_data;
    assign busy      = r_s1_valid || r_res_valid;

endmodule
